ssd_debug_display: RTL and testbench

Parametrised seven-segment debug display driver for the CPU debug port. It replaces the raw 13-bit SSD bus with a multiplexed decimal display. A probe value selected by the CPU top (PC, ALU result, register data, ...) is sampled on `load` and converted to BCD by a sequential double-dabble engine. The result is held in a display buffer and scanned across `DIGITS` digits, with leading-zero blanking, an optional signed mode and overflow indication.

---
 rtl/ssd_debug_display.sv | 200 ++++++++++++++++++++
 tb/tb_ssd_debug_display.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_debug_display.sv
// Multiplexed decimal debug display: samples a probe value, converts it
// to BCD with a serial double-dabble engine and scans it across DIGITS.
module ssd_debug_display #(
    parameter int DATA_W      = 13,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    input  logic              signed_mode,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg
);

    localparam int NB    = DATA_W / 3 + 1;
    localparam int MAG_W = DATA_W + 1;
    localparam int BCD_W = 4 * NB;
    localparam int PAD_N = (NB > DIGITS) ? NB : DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t state_q, state_d;

    logic [MAG_W-1:0]        mag_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    neg_q;
    logic                    done_q;
    logic                    ovf_q;
    logic [DIGITS-1:0][3:0]  buf_q;

    logic                    neg_in;
    logic [MAG_W-1:0]        sext;
    logic [MAG_W-1:0]        mag_in;
    logic [BCD_W-1:0]        bcd_adj;
    logic [4*PAD_N-1:0]      bcd_pad;
    logic [DIGITS-1:0][3:0]  buf_c;
    logic                    ovf_c;
    logic                    lead;
    logic [3:0]              nib;
    int                      avail;

    logic [RC_W-1:0]         refresh_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [DIGITS-1:0]       anode_q;
    logic [6:0]              seg_q;

    function automatic logic [6:0] pattern(input logic [3:0] code);
        logic [6:0] p;
        case (code)
            4'd0:      p = 7'h3F;
            4'd1:      p = 7'h06;
            4'd2:      p = 7'h5B;
            4'd3:      p = 7'h4F;
            4'd4:      p = 7'h66;
            4'd5:      p = 7'h6D;
            4'd6:      p = 7'h7D;
            4'd7:      p = 7'h07;
            4'd8:      p = 7'h7F;
            4'd9:      p = 7'h6F;
            CODE_DASH: p = 7'h40;
            default:   p = 7'h00;
        endcase
        return p;
    endfunction

    // Magnitude is one bit wider so the most-negative input negates exactly.
    assign neg_in = signed_mode & value[DATA_W-1];
    assign sext   = {neg_in, value};
    assign mag_in = neg_in ? (~sext + MAG_W'(1)) : sext;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    assign bcd_pad = (4*PAD_N)'(bcd_q);

    always_comb begin
        avail = neg_q ? DIGITS - 1 : DIGITS;
        ovf_c = 1'b0;
        lead  = 1'b1;
        nib   = 4'd0;
        buf_c = '0;
        for (int i = 0; i < PAD_N; i++) begin
            if (i >= avail && bcd_pad[4*i +: 4] != 4'd0)
                ovf_c = 1'b1;
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd_pad[4*i +: 4];
            if (ovf_c) begin
                buf_c[i] = CODE_DASH;
            end else if (i >= avail) begin
                buf_c[i] = neg_q ? CODE_DASH : CODE_BLANK;
            end else begin
                if (nib != 4'd0)
                    lead = 1'b0;
                buf_c[i] = (lead && i != 0) ? CODE_BLANK : nib;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (bit_cnt == CNT_W'(DATA_W)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            bcd_q    <= '0;
            bit_cnt  <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            buf_q    <= '1;
            buf_q[0] <= 4'd0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        mag_q   <= mag_in;
                        neg_q   <= neg_in;
                        bcd_q   <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    bit_cnt        <= bit_cnt + CNT_W'(1);
                end
                COMMIT: begin
                    buf_q  <= buf_c;
                    ovf_q  <= ovf_c;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs reload only at the start of a scan period, so a buffer
    // update never changes the lit digit part-way through its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            anode_q     <= {DIGITS{ACTIVE_LOW}};
            seg_q       <= {7{ACTIVE_LOW}};
        end else begin
            if (refresh_cnt == RC_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                if (digit_idx == IDX_W'(DIGITS - 1))
                    digit_idx <= '0;
                else
                    digit_idx <= digit_idx + IDX_W'(1);
            end else begin
                refresh_cnt <= refresh_cnt + RC_W'(1);
            end
            if (refresh_cnt == '0) begin
                anode_q <= (DIGITS'(1) << digit_idx) ^ {DIGITS{ACTIVE_LOW}};
                seg_q   <= pattern(buf_q[digit_idx]) ^ {7{ACTIVE_LOW}};
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign anode    = anode_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_ssd_debug_display.sv
// Scoreboard bench for ssd_debug_display: arithmetic reference model
// of the decimal display, compared when the DUT signals done.
module tb_ssd_debug_display;

    localparam int DW = 13;
    localparam int ND = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] value;
    logic          load;
    logic          signed_mode;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [ND-1:0] anode;
    logic [6:0]    seg;

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;

    typedef struct packed {
        logic                 ovf;
        logic [ND-1:0][6:0]   segs;
    } exp_t;

    exp_t sb[$];

    ssd_debug_display #(
        .DATA_W(DW),
        .DIGITS(ND),
        .REFRESH_DIV(RD),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .load(load),
        .signed_mode(signed_mode),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .anode(anode),
        .seg(seg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] digit_pat(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'b0111111;
            1: p = 7'b0000110;
            2: p = 7'b1011011;
            3: p = 7'b1001111;
            4: p = 7'b1100110;
            5: p = 7'b1101101;
            6: p = 7'b1111101;
            7: p = 7'b0000111;
            8: p = 7'b1111111;
            default: p = 7'b1101111;
        endcase
        return p;
    endfunction

    function automatic exp_t model(input logic [DW-1:0] v, input logic s);
        exp_t e;
        int   sv, m, avail, p10, pw;
        bit   neg;
        logic [6:0] act;
        sv    = (s && v[DW-1]) ? int'(v) - (1 << DW) : int'(v);
        neg   = (sv < 0);
        m     = neg ? -sv : sv;
        avail = neg ? ND - 1 : ND;
        p10   = 1;
        for (int k = 0; k < avail; k++) p10 *= 10;
        e.ovf = (m >= p10);
        pw    = 1;
        for (int i = 0; i < ND; i++) begin
            if (e.ovf)          act = 7'b1000000;
            else if (i >= avail) act = 7'b1000000;
            else if (i > 0 && m < pw) act = 7'b0000000;
            else                act = digit_pat((m / pw) % 10);
            e.segs[i] = ~act;
            pw *= 10;
        end
        return e;
    endfunction

    task automatic read_display(output logic [ND-1:0][6:0] segs);
        logic [ND-1:0] oh;
        segs = 'x;
        for (int c = 0; c < ND * RD; c++) begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) begin
                oh = ~(ND'(1) << i);
                if (anode === oh) segs[i] = seg;
            end
        end
    endtask

    task automatic check_display(input string tag,
                                 input logic [ND-1:0][6:0] exp);
        logic [ND-1:0][6:0] got;
        read_display(got);
        for (int i = 0; i < ND; i++)
            check($sformatf("%s_d%0d", tag, i), got[i], exp[i]);
    endtask

    task automatic convert(input string tag, input logic [DW-1:0] v,
                           input logic s, input bit inject);
        exp_t e;
        int   n;
        int   d0;
        bit   seen;
        sb.push_back(model(v, s));
        d0 = done_seen;
        @(negedge clk);
        value = v; signed_mode = s; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        seen = 0;
        n    = 0;
        while (!seen && n < 40) begin
            if (inject && n == 5) begin
                value = 13'd777; signed_mode = 1'b0; load = 1'b1;
            end
            @(posedge clk); #1;
            load = 1'b0;
            n++;
            if (done === 1'b1) seen = 1;
        end
        check({tag, "_done_lat"}, n, 15);
        check({tag, "_busy_end"}, busy, 0);
        e = sb.pop_front();
        check({tag, "_ovf"}, overflow, e.ovf);
        repeat (2) @(posedge clk);
        check_display(tag, e.segs);
        check({tag, "_done_cnt"}, done_seen - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ND-1:0] oh;
        logic [ND-1:0][6:0] rst_disp;
        int d0;
        rst_disp = {7'h7F, 7'h7F, 7'h7F, 7'b1000000};
        rst = 1'b1; load = 1'b0; value = '0; signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk); #1;
        check("first_anode", anode, 4'b1110);
        check("first_seg", seg, 7'b1000000);
        for (int j = 1; j < 16; j++) begin
            @(posedge clk); #1;
            oh = ~(ND'(1) << (j / 4));
            check($sformatf("scan_%0d", j), anode, oh);
        end
        check_display("idle", rst_disp);

        convert("u1234", 13'd1234, 1'b0, 1'b0);
        convert("u42", 13'd42, 1'b0, 1'b0);
        convert("u0", 13'd0, 1'b0, 1'b0);
        convert("sm5", 13'h1FFB, 1'b1, 1'b0);
        convert("sm4096", 13'h1000, 1'b1, 1'b0);
        convert("u8191", 13'd8191, 1'b0, 1'b0);
        convert("u1234_inj", 13'd1234, 1'b0, 1'b1);

        @(negedge clk);
        value = 13'd4321; signed_mode = 1'b0; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1 check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_seen;
        repeat (40) @(posedge clk);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_ovf", overflow, 0);
        check_display("abort", rst_disp);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
